uart_rx: RTL
============

# uart_rx

Oversampling UART receiver that turns the asynchronous serial input into parallel bytes. It consumes the `OSR`×baud tick produced by the baud-rate generator and feeds received bytes to the peripheral's register/FIFO stage. The start, data and stop bits are each decided by a 3-sample majority vote at mid-bit. The block reports a one-cycle valid strobe per good frame and a one-cycle error strobe per bad stop bit.

## Interface
- `OSR`, default `uart_pkg::OSR` (16): ticks per bit; must be ≥ 8 and even.
- `DATALEN`, default `uart_pkg::DATALEN` (8): data bits per frame, LSB first, no parity.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset. The block has one clock; reset is synchronous and active-high.
- `i_tick` in 1: one-`clk` pulse at `OSR`×baud. May be held high, meaning one tick per `clk`.
- `rx` in 1: asynchronous serial line, idle high.
- `rx_data` out `DATALEN`: last good byte; held until the next good frame.
- `rx_valid` out 1: one-cycle pulse when `rx_data` is updated.
- `frame_err` out 1: one-cycle pulse when the stop bit votes 0.
- `rx_busy` out 1: high in every state except IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops to give `rx_s`. Both flops reset to 1. All decisions use `rx_s`.
- **`armed` flag:** set on any `i_tick` where IDLE sees `rx_s`=1. Cleared on reset and on leaving IDLE.
  - A start bit is accepted only when `armed`=1, so a held-low line (break) cannot retrigger.
- **Tick-only updates:** `tick_cnt` (width `$clog2(OSR)`), `bit_cnt` (width `$clog2(DATALEN)`), the shift register and the FSM change only on `i_tick`. Without ticks the FSM is frozen.
- **Vote:** samples are taken at `tick_cnt` = `OSR/2-1`, `OSR/2` and `OSR/2+1` (7, 8, 9). `vote` is the majority of the 3 samples.
- **FSM states** use `uart_pkg::states_e`:
  - **IDLE:** on a tick with `armed` and `rx_s`=0, go to START with `tick_cnt`=0.
  - **START:** increment `tick_cnt` per tick.
    - At `OSR/2+1`, if `vote`=1 (false start), go to IDLE.
    - Otherwise, at `OSR-1`, go to DATA with `tick_cnt`=0 and `bit_cnt`=0.
  - **DATA:** at `OSR/2+1`, shift `vote` into the MSB of the shift register (right shift).
    - At `OSR-1`: if `bit_cnt`=`DATALEN-1`, go to STOP with `tick_cnt`=0; otherwise increment `bit_cnt` and clear `tick_cnt`.
  - **STOP:** at `OSR/2+1`, decide and go to IDLE. The block does not wait for the end of the stop bit, which tolerates baud mismatch on back-to-back frames.
    - `vote`=1: load `rx_data` from the shift register and pulse `rx_valid`.
    - `vote`=0: pulse `frame_err`; `rx_data` is unchanged.
- **Mid-frame reset:** returns to IDLE with no strobe. Reception restarts only after `rx_s` is seen high.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `frame_err`=0, `rx_busy`=0, state IDLE, counters 0, `armed`=0.
- **Input latency:** a change on `rx` reaches `rx_s` 2 `clk` later.
- **Output strobes:** `rx_valid` and `frame_err` are registered. They are high for exactly the one `clk` after the STOP decision tick, and are never high together.
- **`rx_data` timing:** changes in the same cycle `rx_valid` rises.
- **Frame length:** start-edge tick to strobe is `OSR`×(1+`DATALEN`) + `OSR/2`+2 ticks, i.e. 154 ticks at the defaults.

## Structure
- **`uart_pkg`:** `OSR`, `DATALEN` and `states_e` (IDLE/START/DATA/STOP) stay in `uart_pkg`. Add `localparam int SAMPLE_MID = OSR/2` there.
- **Sub-module `sync_2ff`:** 1-bit, with a reset-value parameter. It is shared with other async peripheral inputs.
- **Parent integration:** the tick source is instantiated in the parent, not here.

## Test plan
- **Good frame:** `i_tick` held high; send 0x55 at 16 clk/bit → exactly one `rx_valid`, `rx_data`=0x55, `frame_err` never high.
- **False start:** `rx` low for 4 ticks then high → no strobes, `rx_busy` drops by tick 10, and a following 0xA3 frame is received correctly.
- **Framing error / break:** 0xA3 sent after a good 0x55, with the stop bit held 0 and the line held low for 40 more bits → exactly one `frame_err`, `rx_data` stays 0x55, no retrigger. After the line returns high, 0x3C is received.
- **Majority correction:** 0x0F frame with bit 2 inverted for only the vote-window tick 8 → `rx_data`=0x0F.
- **Reset mid-frame:** `reset` for 1 clk in the middle of bit 4 of 0xFF → `rx_busy`=0 next cycle, no strobe, `rx_data`=0.
- **Back-to-back frames:** 0x00 then 0xFF with a stop bit of exactly 16 ticks → two `rx_valid` pulses, values in order. The second start is detected within 1 tick of its falling edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
package uart_pkg;

    localparam int OSR        = 16;      // oversampling ticks per bit
    localparam int DATALEN    = 8;       // data bits per frame
    localparam int SAMPLE_MID = OSR / 2; // centre tick of a bit

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } states_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the async input, then re-register it to settle metastability.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with 3-sample mid-bit majority voting.
module uart_rx #(
    parameter int OSR     = uart_pkg::OSR,
    parameter int DATALEN = uart_pkg::DATALEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_tick,
    input  logic               rx,
    output logic [DATALEN-1:0] rx_data,
    output logic               rx_valid,
    output logic               frame_err,
    output logic               rx_busy
);

    import uart_pkg::*;

    localparam int TW = $clog2(OSR);
    localparam int BW = $clog2(DATALEN);

    // Tick positions inside a bit: two early samples, then the decision tick
    // which also supplies the third sample straight from the line.
    localparam logic [TW-1:0] T_S0  = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OSR / 2);
    localparam logic [TW-1:0] T_DEC = TW'(OSR / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OSR - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATALEN - 1);

    states_e            state, state_n;
    logic [TW-1:0]      tick_cnt, tick_n;
    logic [BW-1:0]      bit_cnt, bit_n;
    logic [DATALEN-1:0] shreg, shreg_n;
    logic [DATALEN-1:0] data_n;
    logic [1:0]         samp, samp_n;
    logic               armed, armed_n;
    logic               valid_n, ferr_n;
    logic               rx_s;
    logic               vote;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    // Majority of the two stored samples and the live sample at the decision tick.
    assign vote = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

    assign rx_busy = (state != IDLE);

    // Next-state, counter, shift and strobe logic; everything but the strobes holds without a tick.
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        samp_n  = samp;
        armed_n = armed;
        data_n  = rx_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;

        if (i_tick) begin
            if (state != IDLE) begin
                tick_n = tick_cnt + 1'b1;
                if (tick_cnt == T_S0) samp_n[0] = rx_s;
                if (tick_cnt == T_S1) samp_n[1] = rx_s;
            end

            case (state)
                IDLE: begin
                    // A start is only taken after the line has been seen idle,
                    // so a held-low break cannot retrigger.
                    if (rx_s) begin
                        armed_n = 1'b1;
                    end else if (armed) begin
                        state_n = START;
                        tick_n  = '0;
                        armed_n = 1'b0;
                    end
                end
                START: begin
                    if (tick_cnt == T_DEC && vote) begin
                        state_n = IDLE;
                    end else if (tick_cnt == T_END) begin
                        state_n = DATA;
                        tick_n  = '0;
                        bit_n   = '0;
                    end
                end
                DATA: begin
                    if (tick_cnt == T_DEC) shreg_n = {vote, shreg[DATALEN-1:1]};
                    if (tick_cnt == T_END) begin
                        tick_n = '0;
                        if (bit_cnt == B_LAST) state_n = STOP;
                        else                   bit_n   = bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Decide mid-stop-bit and return to IDLE early so a fast
                    // sender's next start edge is not missed.
                    if (tick_cnt == T_DEC) begin
                        state_n = IDLE;
                        if (vote) begin
                            data_n  = shreg;
                            valid_n = 1'b1;
                        end else begin
                            ferr_n = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Control state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            armed     <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            armed     <= armed_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
        end
    end

    // Shift register and vote samples; always written before being consumed.
    always_ff @(posedge clk) begin
        shreg <= shreg_n;
        samp  <= samp_n;
    end

endmodule
